// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port RAM between the
// instruction-fetch (read-only) and load/store requesters; one transaction in flight.
module mem_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int RAM_SIZE   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction-fetch port
  input  logic                  if_valid_i,
  output logic                  if_ready_o,
  input  logic [RAM_SIZE-1:0]   if_addr_i,
  output logic                  if_rvalid_o,
  input  logic                  if_rready_i,
  output logic [31:0]           if_rdata_o,
  // load/store port
  input  logic                  ls_valid_i,
  output logic                  ls_ready_o,
  input  logic                  ls_we_i,
  input  logic [2:0]            ls_wid_i,
  input  logic [RAM_SIZE-1:0]   ls_addr_i,
  input  logic [DATA_WIDTH-1:0] ls_wdata_i,
  output logic                  ls_rvalid_o,
  input  logic                  ls_rready_i,
  output logic [DATA_WIDTH-1:0] ls_rdata_o,
  // RAM side
  output logic [RAM_SIZE-1:0]   ram_addr_o,
  output logic                  ram_ewr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic [2:0]            ram_wid_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  // debug view of the sequencer state
  output logic [1:0]            dbg_state_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RSP_IF = 2'd1;
  localparam logic [1:0] ST_RSP_LS = 2'd2;

  localparam logic [2:0] WID_D  = 3'b011;
  localparam logic [2:0] WID_WU = 3'b110;

  logic [1:0]            state_q, state_d;
  logic                  last_ls_q, last_ls_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic rsp_hs;
  logic slot_free;
  logic if_elig, ls_elig;
  logic grant_if, grant_ls;

  // Handshakes: a request transfers in a cycle where valid and ready are both
  // high; a response transfers where rvalid and rready are both high. Valid
  // may drop at any time without effect, and rdata holds until the transfer.
  assign rsp_hs = ((state_q == ST_RSP_IF) && if_rready_i) ||
                  ((state_q == ST_RSP_LS) && ls_rready_i);

  // Any state that is not holding a response (including the unused encoding)
  // accepts work, so the sequencer can never lock up.
  assign slot_free = !rst &&
                     (((state_q != ST_RSP_IF) && (state_q != ST_RSP_LS)) || rsp_hs);

  assign if_elig = if_valid_i && slot_free;
  assign ls_elig = ls_valid_i && slot_free;

  // last_ls_q = 1 means LS won most recently, so IF takes the next tie.
  assign grant_if = if_elig && (!ls_elig || last_ls_q);
  assign grant_ls = ls_elig && (!if_elig || !last_ls_q);

  assign if_ready_o = grant_if;
  assign ls_ready_o = grant_ls;

  // RAM drive: idle defaults keep the RAM in a harmless read.
  always_comb begin
    ram_addr_o = '0;
    ram_ewr_o  = 1'b1;
    ram_data_o = '0;
    ram_wid_o  = WID_D;
    if (grant_if) begin
      ram_addr_o = if_addr_i;
      ram_wid_o  = WID_WU;
    end else if (grant_ls) begin
      ram_addr_o = ls_addr_i;
      ram_ewr_o  = !ls_we_i;
      ram_data_o = ls_wdata_i;
      ram_wid_o  = ls_wid_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_ls_d  = last_ls_q;
    rsp_data_d = rsp_data_q;
    if (rsp_hs) begin
      state_d = ST_IDLE;
    end
    if (grant_if) begin
      state_d    = ST_RSP_IF;
      last_ls_d  = 1'b0;
      rsp_data_d = {{(DATA_WIDTH-32){1'b0}}, ram_data_i[31:0]};
    end else if (grant_ls) begin
      state_d    = ST_RSP_LS;
      last_ls_d  = 1'b1;
      rsp_data_d = ls_we_i ? '0 : ram_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_ls_q  <= 1'b1;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      last_ls_q  <= last_ls_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign if_rvalid_o = (state_q == ST_RSP_IF);
  assign ls_rvalid_o = (state_q == ST_RSP_LS);
  assign if_rdata_o  = rsp_data_q[31:0];
  assign ls_rdata_o  = rsp_data_q;
  assign dbg_state_o = state_q;

  // The RAM may only see a write strobe for an accepted store.
  always_comb begin
    assert (!(if_ready_o && ls_ready_o));
    assert (ram_ewr_o || (ls_ready_o && ls_we_i));
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural width-aware RAM model and
// hand-computed expectations for each scenario.
module tb_mem_arbiter;

  localparam int DW = 64;
  localparam int AW = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RSP_IF = 2'd1;
  localparam logic [1:0] ST_RSP_LS = 2'd2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_valid_i = 1'b0;
  logic          if_ready_o;
  logic [AW-1:0] if_addr_i = '0;
  logic          if_rvalid_o;
  logic          if_rready_i = 1'b0;
  logic [31:0]   if_rdata_o;
  logic          ls_valid_i = 1'b0;
  logic          ls_ready_o;
  logic          ls_we_i = 1'b0;
  logic [2:0]    ls_wid_i = 3'b011;
  logic [AW-1:0] ls_addr_i = '0;
  logic [DW-1:0] ls_wdata_i = '0;
  logic          ls_rvalid_o;
  logic          ls_rready_i = 1'b0;
  logic [DW-1:0] ls_rdata_o;
  logic [AW-1:0] ram_addr_o;
  logic          ram_ewr_o;
  logic [DW-1:0] ram_data_o;
  logic [2:0]    ram_wid_o;
  logic [DW-1:0] ram_data_i;
  logic [1:0]    dbg_state_o;

  int checks = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .RAM_SIZE(AW)) dut (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_addr_i(if_addr_i),
    .if_rvalid_o(if_rvalid_o), .if_rready_i(if_rready_i), .if_rdata_o(if_rdata_o),
    .ls_valid_i(ls_valid_i), .ls_ready_o(ls_ready_o), .ls_we_i(ls_we_i),
    .ls_wid_i(ls_wid_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_rvalid_o(ls_rvalid_o), .ls_rready_i(ls_rready_i), .ls_rdata_o(ls_rdata_o),
    .ram_addr_o(ram_addr_o), .ram_ewr_o(ram_ewr_o), .ram_data_o(ram_data_o),
    .ram_wid_o(ram_wid_o), .ram_data_i(ram_data_i), .dbg_state_o(dbg_state_o)
  );

  // RAM model: combinational extended read, width-masked write on posedge
  logic [DW-1:0] mem [0:15];
  logic [DW-1:0] word;

  always_comb begin
    word = mem[ram_addr_o[3:0]];
    case (ram_wid_o)
      3'b000:  ram_data_i = {{56{word[7]}}, word[7:0]};
      3'b001:  ram_data_i = {{48{word[15]}}, word[15:0]};
      3'b010:  ram_data_i = {{32{word[31]}}, word[31:0]};
      3'b100:  ram_data_i = {56'd0, word[7:0]};
      3'b101:  ram_data_i = {48'd0, word[15:0]};
      3'b110:  ram_data_i = {32'd0, word[31:0]};
      default: ram_data_i = word;
    endcase
  end

  always @(posedge clk) begin
    if (!ram_ewr_o) begin
      case (ram_wid_o)
        3'b000: mem[ram_addr_o[3:0]][7:0]  <= ram_data_o[7:0];
        3'b001: mem[ram_addr_o[3:0]][15:0] <= ram_data_o[15:0];
        3'b010: mem[ram_addr_o[3:0]][31:0] <= ram_data_o[31:0];
        3'b011: mem[ram_addr_o[3:0]]       <= ram_data_o;
        default: ;
      endcase
    end
  end

  // driver tasks
  task automatic idle_inputs();
    if_valid_i = 1'b0;
    ls_valid_i = 1'b0;
    ls_we_i    = 1'b0;
    ls_wid_i   = 3'b011;
    ls_wdata_i = '0;
  endtask

  task automatic drive_ls(input logic we, input logic [2:0] wid,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    ls_valid_i = 1'b1;
    ls_we_i    = we;
    ls_wid_i   = wid;
    ls_addr_i  = addr;
    ls_wdata_i = wdata;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    if_valid_i = 1'b1; ls_valid_i = 1'b1; if_addr_i = 16'd5; ls_addr_i = 16'd3;
    #1;
    checks++; if (if_ready_o !== 1'b0) begin failures++; $display("FAIL rst_if_ready got=%b exp=0", if_ready_o); end
    checks++; if (ls_ready_o !== 1'b0) begin failures++; $display("FAIL rst_ls_ready got=%b exp=0", ls_ready_o); end
    @(negedge clk);
    #1;
    checks++; if (if_rvalid_o !== 1'b0 || ls_rvalid_o !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b%b exp=00", if_rvalid_o, ls_rvalid_o); end
    checks++; if (ls_rdata_o !== 64'd0 || if_rdata_o !== 32'd0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", ls_rdata_o); end
    checks++; if (ram_ewr_o !== 1'b1 || ram_wid_o !== 3'b011 || ram_addr_o !== 16'd0 || ram_data_o !== 64'd0) begin
      failures++; $display("FAIL rst_ram_drive got ewr=%b wid=%b addr=%h data=%h exp 1/011/0/0", ram_ewr_o, ram_wid_o, ram_addr_o, ram_data_o); end
    checks++; if (dbg_state_o !== ST_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=0", dbg_state_o); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_if_read();
    @(negedge clk);
    if_valid_i = 1'b1; if_addr_i = 16'd5; if_rready_i = 1'b1;
    #1;
    checks++; if (if_ready_o !== 1'b1) begin failures++; $display("FAIL ifrd_ready got=%b exp=1", if_ready_o); end
    checks++; if (ram_ewr_o !== 1'b1 || ram_addr_o !== 16'd5 || ram_wid_o !== 3'b110) begin
      failures++; $display("FAIL ifrd_ram got ewr=%b addr=%h wid=%b exp 1/0005/110", ram_ewr_o, ram_addr_o, ram_wid_o); end
    @(negedge clk);
    if_valid_i = 1'b0;
    #1;
    checks++; if (if_rvalid_o !== 1'b1) begin failures++; $display("FAIL ifrd_rvalid got=%b exp=1", if_rvalid_o); end
    checks++; if (if_rdata_o !== 32'h8000_0001) begin failures++; $display("FAIL ifrd_rdata got=%h exp=80000001", if_rdata_o); end
    checks++; if (ram_ewr_o !== 1'b1 || ram_wid_o !== 3'b011) begin failures++; $display("FAIL ifrd_ram_idle got ewr=%b wid=%b exp 1/011", ram_ewr_o, ram_wid_o); end
    @(negedge clk);
    #1;
    checks++; if (if_rvalid_o !== 1'b0 || dbg_state_o !== ST_IDLE) begin failures++; $display("FAIL ifrd_done got rvalid=%b state=%0d exp 0/0", if_rvalid_o, dbg_state_o); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_ls(1'b1, 3'b011, 16'd3, 64'h1122_3344_5566_7788); ls_rready_i = 1'b1;
    #1;
    checks++; if (ls_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_st_ready got=%b exp=1", ls_ready_o); end
    checks++; if (ram_ewr_o !== 1'b0 || ram_addr_o !== 16'd3 || ram_data_o !== 64'h1122_3344_5566_7788) begin
      failures++; $display("FAIL b2b_st_ram got ewr=%b addr=%h data=%h exp 0/0003/1122334455667788", ram_ewr_o, ram_addr_o, ram_data_o); end
    @(negedge clk);
    drive_ls(1'b0, 3'b000, 16'd3, 64'd0);
    #1;
    checks++; if (ls_rvalid_o !== 1'b1 || ls_rdata_o !== 64'd0) begin failures++; $display("FAIL b2b_st_ack got rvalid=%b rdata=%h exp 1/0", ls_rvalid_o, ls_rdata_o); end
    checks++; if (ls_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ldb_ready got=%b exp=1", ls_ready_o); end
    @(negedge clk);
    drive_ls(1'b0, 3'b100, 16'd3, 64'd0);
    #1;
    checks++; if (ls_rvalid_o !== 1'b1 || ls_rdata_o !== 64'hFFFF_FFFF_FFFF_FF88) begin
      failures++; $display("FAIL b2b_ldb_rdata got=%h exp=ffffffffffffff88", ls_rdata_o); end
    checks++; if (ls_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ldbu_ready got=%b exp=1", ls_ready_o); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (ls_rvalid_o !== 1'b1 || ls_rdata_o !== 64'h88) begin failures++; $display("FAIL b2b_ldbu_rdata got=%h exp=88", ls_rdata_o); end
    @(negedge clk);
    #1;
    checks++; if (dbg_state_o !== ST_IDLE) begin failures++; $display("FAIL b2b_idle got=%0d exp=0", dbg_state_o); end
  endtask

  task automatic test_contention();
    logic exp_if;
    if_rready_i = 1'b1; ls_rready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if_valid_i = 1'b1; if_addr_i = 16'd5;
      drive_ls(1'b0, 3'b011, 16'd3, 64'd0);
      #1;
      exp_if = (k % 2 == 0);
      checks++; if (if_ready_o !== exp_if || ls_ready_o !== !exp_if) begin
        failures++; $display("FAIL rr_grant_%0d got if=%b ls=%b exp if=%b", k, if_ready_o, ls_ready_o, exp_if); end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (ls_rvalid_o !== 1'b1 || ls_rdata_o !== 64'h1122_3344_5566_7788) begin
      failures++; $display("FAIL rr_last_rdata got=%h exp=1122334455667788", ls_rdata_o); end
    @(negedge clk);
  endtask

  task automatic test_hold();
    @(negedge clk);
    if_valid_i = 1'b1; if_addr_i = 16'd5; if_rready_i = 1'b0; ls_rready_i = 1'b1;
    drive_ls(1'b0, 3'b011, 16'd3, 64'd0);
    #1;
    checks++; if (if_ready_o !== 1'b1 || ls_ready_o !== 1'b0) begin failures++; $display("FAIL hold_first got if=%b ls=%b exp 1/0", if_ready_o, ls_ready_o); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if_valid_i = 1'b0;
      #1;
      checks++; if (ls_ready_o !== 1'b0) begin failures++; $display("FAIL hold_ls_ready_%0d got=%b exp=0", i, ls_ready_o); end
      checks++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h8000_0001) begin
        failures++; $display("FAIL hold_if_rdata_%0d got rvalid=%b rdata=%h exp 1/80000001", i, if_rvalid_o, if_rdata_o); end
    end
    @(negedge clk);
    if_rready_i = 1'b1;
    #1;
    checks++; if (ls_ready_o !== 1'b1 || if_ready_o !== 1'b0) begin failures++; $display("FAIL hold_release got ls=%b if=%b exp 1/0", ls_ready_o, if_ready_o); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (ls_rvalid_o !== 1'b1 || if_rvalid_o !== 1'b0 || ls_rdata_o !== 64'h1122_3344_5566_7788) begin
      failures++; $display("FAIL hold_ls_rsp got rvalid=%b/%b rdata=%h exp 1/0/1122334455667788", ls_rvalid_o, if_rvalid_o, ls_rdata_o); end
    @(negedge clk);
  endtask

  task automatic test_bad_width_store();
    @(negedge clk);
    drive_ls(1'b1, 3'b100, 16'd7, 64'hFFFF_FFFF_FFFF_FFFF); ls_rready_i = 1'b1;
    #1;
    checks++; if (ls_ready_o !== 1'b1 || ram_ewr_o !== 1'b0 || ram_wid_o !== 3'b100) begin
      failures++; $display("FAIL badw_accept got ready=%b ewr=%b wid=%b exp 1/0/100", ls_ready_o, ram_ewr_o, ram_wid_o); end
    @(negedge clk);
    drive_ls(1'b0, 3'b011, 16'd7, 64'd0);
    #1;
    checks++; if (ls_rvalid_o !== 1'b1 || ls_rdata_o !== 64'd0) begin failures++; $display("FAIL badw_ack got rvalid=%b rdata=%h exp 1/0", ls_rvalid_o, ls_rdata_o); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (ls_rdata_o !== 64'hAB) begin failures++; $display("FAIL badw_readback got=%h exp=ab", ls_rdata_o); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_ls(1'b0, 3'b011, 16'd3, 64'd0); ls_rready_i = 1'b0;
    #1;
    checks++; if (ls_ready_o !== 1'b1) begin failures++; $display("FAIL rmid_grant got=%b exp=1", ls_ready_o); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (dbg_state_o !== ST_RSP_LS || ls_rvalid_o !== 1'b1) begin failures++; $display("FAIL rmid_pending got state=%0d rvalid=%b exp 2/1", dbg_state_o, ls_rvalid_o); end
    @(negedge clk);
    rst = 1'b1; ls_valid_i = 1'b1; if_valid_i = 1'b1;
    #1;
    checks++; if (ls_ready_o !== 1'b0 || if_ready_o !== 1'b0) begin failures++; $display("FAIL rmid_ready_in_rst got ls=%b if=%b exp 0/0", ls_ready_o, if_ready_o); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++; if (ls_rvalid_o !== 1'b0 || dbg_state_o !== ST_IDLE || ls_rdata_o !== 64'd0) begin
      failures++; $display("FAIL rmid_dropped got rvalid=%b state=%0d rdata=%h exp 0/0/0", ls_rvalid_o, dbg_state_o, ls_rdata_o); end
    // make IF the last winner, then confirm reset restores IF priority on a tie
    @(negedge clk);
    if_valid_i = 1'b1; if_addr_i = 16'd5; if_rready_i = 1'b1; ls_rready_i = 1'b1;
    #1;
    checks++; if (if_ready_o !== 1'b1) begin failures++; $display("FAIL rmid_if_grant got=%b exp=1", if_ready_o); end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if_valid_i = 1'b1;
    drive_ls(1'b0, 3'b011, 16'd3, 64'd0);
    #1;
    checks++; if (if_ready_o !== 1'b1 || ls_ready_o !== 1'b0) begin failures++; $display("FAIL rmid_tie_after_rst got if=%b ls=%b exp 1/0", if_ready_o, ls_ready_o); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h8000_0001) begin failures++; $display("FAIL rmid_if_rsp got rvalid=%b rdata=%h exp 1/80000001", if_rvalid_o, if_rdata_o); end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[5] = 64'hFFFF_FFFF_8000_0001;
    mem[7] = 64'h0000_0000_0000_00AB;
    test_reset();
    test_if_read();
    test_back_to_back();
    test_contention();
    test_hold();
    test_bad_width_store();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
